// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode classes
// and the datapath mux selects.
package controle_pkg;
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, PCUPD} estado_t;
    typedef enum logic [2:0] {CL_R, CL_I, CL_J, CL_B, CL_ILL} classe_t;

    localparam int OP_JUMP = 11;
    localparam int OP_BEQ  = 12;

    localparam logic [1:0] B_REG = 2'b00;
    localparam logic [1:0] B_UM  = 2'b01;
    localparam logic [1:0] B_IMM = 2'b10;

    localparam logic [1:0] CP_INC = 2'b00;
    localparam logic [1:0] CP_ULA = 2'b01;
    localparam logic [1:0] CP_JMP = 2'b10;
endpackage

// File: rtl/controle_multiciclo_if.sv
// Fetch handshake plus datapath control bundle; master is the controller side.
interface controle_multiciclo_if #(
    parameter int OPW   = 4,
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [OPW-1:0]   opcode;
    logic             ula_zero;
    logic             esc_cond_cp;
    logic             esc_cp;
    logic             esc_ir;
    logic             esc_reg;
    logic             ula_a;
    logic [1:0]       ula_b;
    logic [OPW-1:0]   ula_op;
    logic [1:0]       fonte_cp;
    logic             instr_done;
    logic             erro_opcode;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr_valid, opcode, ula_zero,
        output instr_ready, esc_cond_cp, esc_cp, esc_ir, esc_reg, ula_a, ula_b,
               ula_op, fonte_cp, instr_done, erro_opcode, retired
    );
    modport slave (
        output instr_valid, opcode, ula_zero,
        input  instr_ready, esc_cond_cp, esc_cp, esc_ir, esc_reg, ula_a, ula_b,
               ula_op, fonte_cp, instr_done, erro_opcode, retired
    );
endinterface

// File: rtl/controle_multiciclo_decod.sv
// Opcode-to-class decoder; purely combinational.
module controle_decod
    import controle_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] opcode,
    output classe_t        classe
);
    always_comb begin
        classe = CL_ILL;
        case (32'(opcode))
            0, 1, 3, 4, 5:     classe = CL_R;
            2, 6, 7, 8, 9, 10: classe = CL_I;
            OP_JUMP:           classe = CL_J;
            OP_BEQ:            classe = CL_B;
            default:           classe = CL_ILL;
        endcase
    end
endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle Moore control unit: FETCH/DECODE/EXEC/WB/PCUPD with registered
// outputs that always line up with the state they belong to.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int EXEC_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    controle_multiciclo_if.master bus
);
    estado_t    estado;
    classe_t    cls, cls_in;
    logic [3:0] cnt;
    logic       unused_zero;

    // Taken/not-taken is resolved in the datapath, never here.
    assign unused_zero = bus.ula_zero;

    controle_decod #(.OPW(OPW)) u_decod (.opcode(bus.opcode), .classe(cls_in));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado          <= FETCH;
            cls             <= CL_R;
            cnt             <= '0;
            bus.instr_ready <= 1'b0;
            bus.esc_ir      <= 1'b0;
            bus.esc_reg     <= 1'b0;
            bus.esc_cp      <= 1'b0;
            bus.esc_cond_cp <= 1'b0;
            bus.ula_a       <= 1'b0;
            bus.ula_b       <= B_REG;
            bus.ula_op      <= '0;
            bus.fonte_cp    <= CP_INC;
            bus.instr_done  <= 1'b0;
            bus.erro_opcode <= 1'b0;
            bus.retired     <= '0;
        end else begin
            bus.instr_ready <= 1'b0;
            bus.esc_ir      <= 1'b0;
            bus.esc_reg     <= 1'b0;
            bus.esc_cp      <= 1'b0;
            bus.esc_cond_cp <= 1'b0;
            bus.instr_done  <= 1'b0;
            case (estado)
                FETCH: begin
                    // Classify the incoming opcode now so the error flag shows in DECODE.
                    if (bus.instr_ready && bus.instr_valid) begin
                        estado     <= DECODE;
                        bus.esc_ir <= 1'b1;
                        bus.ula_op <= bus.opcode;
                        cls        <= cls_in;
                        if (cls_in == CL_ILL) bus.erro_opcode <= 1'b1;
                    end else begin
                        bus.instr_ready <= 1'b1;
                    end
                end
                DECODE: begin
                    case (cls)
                        CL_R, CL_I: begin
                            estado    <= EXEC;
                            cnt       <= 4'(EXEC_CYCLES - 1);
                            bus.ula_a <= 1'b1;
                            bus.ula_b <= (cls == CL_I) ? B_IMM : B_REG;
                        end
                        CL_B: begin
                            estado    <= EXEC;
                            cnt       <= '0;
                            bus.ula_a <= 1'b1;
                            bus.ula_b <= B_REG;
                        end
                        CL_J: begin
                            estado         <= PCUPD;
                            bus.esc_cp     <= 1'b1;
                            bus.fonte_cp   <= CP_JMP;
                            bus.instr_done <= 1'b1;
                            bus.retired    <= bus.retired + 1'b1;
                        end
                        default: begin
                            estado         <= PCUPD;
                            bus.esc_cp     <= 1'b1;
                            bus.fonte_cp   <= CP_INC;
                            bus.ula_b      <= B_UM;
                            bus.instr_done <= 1'b1;
                            bus.retired    <= bus.retired + 1'b1;
                        end
                    endcase
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (cls == CL_B) begin
                        estado          <= PCUPD;
                        bus.esc_cond_cp <= 1'b1;
                        bus.fonte_cp    <= CP_ULA;
                        bus.ula_a       <= 1'b0;
                        bus.ula_b       <= B_REG;
                        bus.instr_done  <= 1'b1;
                        bus.retired     <= bus.retired + 1'b1;
                    end else begin
                        estado      <= WB;
                        bus.esc_reg <= 1'b1;
                    end
                end
                WB: begin
                    estado         <= PCUPD;
                    bus.esc_cp     <= 1'b1;
                    bus.fonte_cp   <= CP_INC;
                    bus.ula_a      <= 1'b0;
                    bus.ula_b      <= B_UM;
                    bus.instr_done <= 1'b1;
                    bus.retired    <= bus.retired + 1'b1;
                end
                default: begin
                    estado          <= FETCH;
                    bus.instr_ready <= 1'b1;
                    bus.ula_a       <= 1'b0;
                    bus.ula_b       <= B_REG;
                    bus.fonte_cp    <= CP_INC;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: per-cycle control vectors per class.
module tb_controle_multiciclo;
    localparam int OPW = 4;
    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int C_R = 0, C_I = 1, C_J = 2, C_B = 3, C_ILL = 4;

    // {instr_ready, esc_ir, esc_reg, esc_cp, esc_cond_cp, ula_a, ula_b, fonte_cp, instr_done}
    localparam logic [10:0] V_ZERO   = 11'b0_0_0_0_0_0_00_00_0;
    localparam logic [10:0] V_FETCH  = 11'b1_0_0_0_0_0_00_00_0;
    localparam logic [10:0] V_DEC    = 11'b0_1_0_0_0_0_00_00_0;
    localparam logic [10:0] V_EXR    = 11'b0_0_0_0_0_1_00_00_0;
    localparam logic [10:0] V_EXI    = 11'b0_0_0_0_0_1_10_00_0;
    localparam logic [10:0] V_WBR    = 11'b0_0_1_0_0_1_00_00_0;
    localparam logic [10:0] V_WBI    = 11'b0_0_1_0_0_1_10_00_0;
    localparam logic [10:0] V_PCINC  = 11'b0_0_0_1_0_0_01_00_1;
    localparam logic [10:0] V_PCJMP  = 11'b0_0_0_1_0_0_00_10_1;
    localparam logic [10:0] V_PCBR   = 11'b0_0_0_0_1_0_00_01_1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    controle_multiciclo_if #(.OPW(OPW), .CNT_W(CW)) bus ();
    controle_multiciclo #(.OPW(OPW), .EXEC_CYCLES(N), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {bus.instr_ready, bus.esc_ir, bus.esc_reg, bus.esc_cp, bus.esc_cond_cp,
                bus.ula_a, bus.ula_b, bus.fonte_cp, bus.instr_done};
    endfunction

    task automatic run(input logic [3:0] op, input int cls, input bit keep, input string nm);
        int waited = 0;
        logic [3:0] junk;
        bus.instr_valid = 1'b1;
        bus.opcode = op;
        @(negedge clk);
        while (!bus.instr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk({nm, ":fetch"}, 32'(outs()), 32'(V_FETCH));
        @(posedge clk);
        #1;
        junk = ~op;
        bus.opcode = junk;
        if (!keep) bus.instr_valid = 1'b0;
        @(negedge clk);
        chk({nm, ":decode"}, 32'(outs()), 32'(V_DEC));
        chk({nm, ":ula_op"}, 32'(bus.ula_op), 32'(op));
        if (cls == C_R || cls == C_I) begin
            for (int i = 0; i < N; i++) begin
                @(negedge clk);
                chk({nm, ":exec"}, 32'(outs()), 32'((cls == C_I) ? V_EXI : V_EXR));
            end
            @(negedge clk);
            chk({nm, ":wb"}, 32'(outs()), 32'((cls == C_I) ? V_WBI : V_WBR));
        end else if (cls == C_B) begin
            @(negedge clk);
            chk({nm, ":exec"}, 32'(outs()), 32'(V_EXR));
        end
        @(negedge clk);
        chk({nm, ":pcupd"}, 32'(outs()),
            32'((cls == C_J) ? V_PCJMP : (cls == C_B) ? V_PCBR : V_PCINC));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.opcode = '0;
        bus.ula_zero = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outs", 32'(outs()), 32'(V_ZERO));
        chk("rst_retired", 32'(bus.retired), 32'd0);
        rst_n = 1'b1;

        // Abort an R instruction in the middle of EXEC.
        bus.instr_valid = 1'b1;
        bus.opcode = 4'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_exec", 32'(outs()), 32'(V_EXR));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outs", 32'(outs()), 32'(V_ZERO));
        chk("midrst_retired", 32'(bus.retired), 32'd0);
        chk("midrst_ula_op", 32'(bus.ula_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", 32'(bus.instr_ready), 32'd1);

        run(4'd0, C_R, 1'b0, "r0");
        chk("r0_retired", 32'(bus.retired), 32'd1);

        run(4'd6, C_I, 1'b1, "i6");
        run(4'd11, C_J, 1'b0, "j11");
        chk("ij_retired", 32'(bus.retired), 32'd3);

        bus.ula_zero = 1'b1;
        run(4'd12, C_B, 1'b0, "beq_z1");
        bus.ula_zero = 1'b0;
        run(4'd12, C_B, 1'b0, "beq_z0");
        chk("b_retired", 32'(bus.retired), 32'd5);
        chk("erro_before", 32'(bus.erro_opcode), 32'd0);

        run(4'd15, C_ILL, 1'b0, "ill15");
        chk("erro_set", 32'(bus.erro_opcode), 32'd1);
        chk("ill_retired", 32'(bus.retired), 32'd6);
        run(4'd3, C_R, 1'b0, "r3");
        chk("erro_sticky", 32'(bus.erro_opcode), 32'd1);
        chk("r3_retired", 32'(bus.retired), 32'd7);

        bus.instr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle", 32'(outs()), 32'(V_FETCH));
        end
        chk("idle_retired", 32'(bus.retired), 32'd7);

        // Counter wrap: 17 back-to-back jumps on a 4-bit counter.
        rst_n = 1'b0;
        #1;
        chk("rst2_erro", 32'(bus.erro_opcode), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) run(4'd11, C_J, 1'b1, "jwrap");
        bus.instr_valid = 1'b0;
        chk("wrap_retired", 32'(bus.retired), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_idle", 32'(outs()), 32'(V_FETCH));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end
endmodule
